// File: rtl/subtractor_core.sv
// -----------------------------------------------------------------------------
// subtractor_core
//
// Registered unsigned subtractor. Computes A - B (- bin) through a ripple chain
// of 1-bit subtractor slices and registers the difference, the borrow-out, a
// zero flag and the two's-complement overflow flag. Latency is one cycle and a
// new operation can be accepted every cycle.
//
// Parameters:
//   WIDTH       operand / difference width in bits, 1..64.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high (wins over in_valid)
//   in_valid    operands valid this cycle
//   A           minuend, unsigned
//   B           subtrahend, unsigned
//   bin         borrow-in (only when SUBTRACTOR_BORROW_IN_EN is defined)
//   Difference  registered (A - B - bin) mod 2^WIDTH
//   Borrow      registered borrow-out of the MSB slice
//   Zero        registered, 1 when the captured Difference is all zeros
//   Overflow    registered signed overflow of the MSB slice
//   out_valid   registered, a result was captured on the previous edge
//
// Build option:
//   SUBTRACTOR_BORROW_IN_EN  adds the bin port and turns slice 0 into a full
//                            subtractor. Undefined: slice 0 is a half
//                            subtractor and the borrow into it is 0.
// -----------------------------------------------------------------------------
module subtractor_core #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SUBTRACTOR_BORROW_IN_EN
  input  logic             bin,
`endif
  output logic [WIDTH-1:0] Difference,
  output logic             Borrow,
  output logic             Zero,
  output logic             Overflow,
  output logic             out_valid
);

  // borrow[i] is the borrow into slice i; borrow[WIDTH] leaves the MSB slice.
  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff_comb;

  // ---------------------------------------------------------------------------
  // Slice 0: full subtractor fed by bin, or a half subtractor with no borrow-in.
  // ---------------------------------------------------------------------------
`ifdef SUBTRACTOR_BORROW_IN_EN
  assign borrow[0]    = bin;
  assign diff_comb[0] = A[0] ^ B[0] ^ borrow[0];
  assign borrow[1]    = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & borrow[0]);
`else
  assign borrow[0]    = 1'b0;
  assign diff_comb[0] = A[0] ^ B[0];
  assign borrow[1]    = ~A[0] & B[0];
`endif

  // ---------------------------------------------------------------------------
  // Slices 1..WIDTH-1: full subtractors rippling the borrow upward.
  // ---------------------------------------------------------------------------
  for (genvar i = 1; i < WIDTH; i++) begin : g_slice
    assign diff_comb[i] = A[i] ^ B[i] ^ borrow[i];
    assign borrow[i+1]  = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow[i]);
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] diff_d,  diff_q;
  logic             borrow_d, borrow_q;
  logic             zero_d,   zero_q;
  logic             ovf_d,    ovf_q;
  logic             valid_d,  valid_q;

  // NOTE: every next-state signal gets a default (the held value) before any
  // conditional update, so this block can never infer a latch.
  always_comb begin
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    // Only touch the result when operands are valid, so garbage on A/B during
    // idle cycles never reaches the held outputs.
    if (in_valid) begin
      diff_d   = diff_comb;
      borrow_d = borrow[WIDTH];
      zero_d   = (diff_comb == '0);
      // Signed overflow: carries into and out of the MSB slice disagree.
      ovf_d    = borrow[WIDTH] ^ borrow[WIDTH-1];
      valid_d  = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign Difference = diff_q;
  assign Borrow     = borrow_q;
  assign Zero       = zero_q;
  assign Overflow   = ovf_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_subtractor_core.sv
// -----------------------------------------------------------------------------
// tb_subtractor_core
//
// Directed bench for subtractor_core with two instances: WIDTH=1 (clocked half
// subtractor) and WIDTH=8. Stimulus pushes the hand-computed expected result
// into a per-instance queue; a monitor per instance pops and compares whenever
// out_valid is seen. Hold and reset behaviour is checked directly after the
// relevant edge. When SUBTRACTOR_BORROW_IN_EN is defined the bin vectors run too.
// -----------------------------------------------------------------------------
module tb_subtractor_core;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
    logic       z;
    logic       o;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  // WIDTH=1 instance
  logic       v1, a1, b1, bin1;
  logic       d1, bo1, z1, o1, ov1;

  // WIDTH=8 instance
  logic       v8, bin8;
  logic [7:0] a8, b8, d8;
  logic       bo8, z8, o8, ov8;

  exp_t q1[$];
  exp_t q8[$];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  subtractor_core #(.WIDTH(1)) u_w1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (v1),
    .A          (a1),
    .B          (b1),
`ifdef SUBTRACTOR_BORROW_IN_EN
    .bin        (bin1),
`endif
    .Difference (d1),
    .Borrow     (bo1),
    .Zero       (z1),
    .Overflow   (o1),
    .out_valid  (ov1)
  );

  subtractor_core #(.WIDTH(8)) u_w8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (v8),
    .A          (a8),
    .B          (b8),
`ifdef SUBTRACTOR_BORROW_IN_EN
    .bin        (bin8),
`endif
    .Difference (d8),
    .Borrow     (bo8),
    .Zero       (z8),
    .Overflow   (o8),
    .out_valid  (ov8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: sample on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL w1_unexpected_valid: got out_valid=1, expected no result (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("w1_result {d,borrow,zero,ovf}", {28'd0, d1, bo1, z1, o1},
              {28'd0, e.d[0], e.b, e.z, e.o});
      end
    end
  end

  always @(negedge clk) begin
    if (ov8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL w8_unexpected_valid: got out_valid=1, expected no result (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("w8_result {d,borrow,zero,ovf}", {21'd0, d8, bo8, z8, o8},
              {21'd0, e.d, e.b, e.z, e.o});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic op1(input logic a, input logic b, input exp_t e);
    a1 = a; b1 = b; v1 = 1'b1;
    q1.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input exp_t e);
    a8 = a; b8 = b; bin8 = bi; v8 = 1'b1;
    q8.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle8(input logic [7:0] a, input logic [7:0] b);
    a8 = a; b8 = b; bin8 = 1'b1; v8 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_w8_hold(input string name, input logic [7:0] d, input logic b,
                               input logic z, input logic o);
    check({name, "_out_valid"}, {31'd0, ov8}, 32'd0);
    check({name, "_diff"},      {24'd0, d8},  {24'd0, d});
    check({name, "_flags"},     {29'd0, bo8, z8, o8}, {29'd0, b, z, o});
  endtask

  initial begin
    rst = 1'b1;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check_w8_hold("reset_w8", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_w1", {27'd0, ov1, d1, bo1, z1, o1}, 32'd0);
    rst = 1'b0;

    // WIDTH=1 truth table: (A,B) -> d, borrow, zero, ovf
    op1(1'b0, 1'b0, '{d: 8'h00, b: 1'b0, z: 1'b1, o: 1'b0});
    op1(1'b0, 1'b1, '{d: 8'h01, b: 1'b1, z: 1'b0, o: 1'b1});
    op1(1'b1, 1'b0, '{d: 8'h01, b: 1'b0, z: 1'b0, o: 1'b0});
    op1(1'b1, 1'b1, '{d: 8'h00, b: 1'b0, z: 1'b1, o: 1'b0});
    v1 = 1'b0;

    // WIDTH=8 back-to-back vectors
    op8(8'h00, 8'hFF, 1'b0, '{d: 8'h01, b: 1'b1, z: 1'b0, o: 1'b0});
    op8(8'h5A, 8'h5A, 1'b0, '{d: 8'h00, b: 1'b0, z: 1'b1, o: 1'b0});
    op8(8'h80, 8'h01, 1'b0, '{d: 8'h7F, b: 1'b0, z: 1'b0, o: 1'b1});
    op8(8'h7F, 8'hFF, 1'b0, '{d: 8'h80, b: 1'b1, z: 1'b0, o: 1'b1});
    op8(8'hFF, 8'h01, 1'b0, '{d: 8'hFE, b: 1'b0, z: 1'b0, o: 1'b0});
    op8(8'h01, 8'h02, 1'b0, '{d: 8'hFF, b: 1'b1, z: 1'b0, o: 1'b0});
    op8(8'h00, 8'h80, 1'b0, '{d: 8'h80, b: 1'b1, z: 1'b0, o: 1'b1});

    // Hold: capture 0x10 - 0x03, then idle with changing operands
    op8(8'h10, 8'h03, 1'b0, '{d: 8'h0D, b: 1'b0, z: 1'b0, o: 1'b0});
    idle8(8'hA5, 8'h3C);
    check_w8_hold("hold1", 8'h0D, 1'b0, 1'b0, 1'b0);
    idle8(8'h00, 8'hFF);
    check_w8_hold("hold2", 8'h0D, 1'b0, 1'b0, 1'b0);
    idle8('x, 'x);
    check_w8_hold("hold3", 8'h0D, 1'b0, 1'b0, 1'b0);

    // Reset wins over a valid operation sampled on the same edge
    rst = 1'b1;
    a8 = 8'h05; b8 = 8'h09; bin8 = 1'b0; v8 = 1'b1;
    @(posedge clk); #1;
    check_w8_hold("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle8(8'h00, 8'h00);
    check_w8_hold("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    op8(8'h05, 8'h09, 1'b0, '{d: 8'hFC, b: 1'b1, z: 1'b0, o: 1'b0});

`ifdef SUBTRACTOR_BORROW_IN_EN
    op8(8'h00, 8'h00, 1'b1, '{d: 8'hFF, b: 1'b1, z: 1'b0, o: 1'b0});
    op8(8'h00, 8'h00, 1'b0, '{d: 8'h00, b: 1'b0, z: 1'b1, o: 1'b0});
    op8(8'h10, 8'h03, 1'b1, '{d: 8'h0C, b: 1'b0, z: 1'b0, o: 1'b0});
`endif

    // Drain: bounded wait for every expected result to be observed
    v8 = 1'b0;
    for (int i = 0; i < 5 && (q1.size() != 0 || q8.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    while (q1.size() != 0) begin
      exp_t e;
      e = q1.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL w1_missing_result: got no out_valid, expected d=%0h", e.d[0]);
    end
    while (q8.size() != 0) begin
      exp_t e;
      e = q8.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL w8_missing_result: got no out_valid, expected d=%0h", e.d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/subtractor_core.md
Name: subtractor_core

Overview:
- Registered unsigned subtractor: computes A minus B and produces difference and borrow-out.
- Built from a ripple chain of 1-bit subtractor slices. Slice 0 is a half subtractor, or a full subtractor when the optional borrow-in is compiled in. Slices 1..WIDTH-1 are full subtractors.
- Used as the arithmetic leaf in datapath blocks.
- With WIDTH=1 it is a clocked half subtractor.

Parameters:
- WIDTH, 1, operand and difference width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands valid this cycle.
- A  input  WIDTH  minuend, unsigned.
- B  input  WIDTH  subtrahend, unsigned.
- Difference  output  WIDTH  registered (A - B - bin) mod 2^WIDTH.
- Borrow  output  1  registered borrow-out of MSB slice.
- Zero  output  1  registered; 1 when the captured Difference is all zeros.
- Overflow  output  1  registered signed overflow of the MSB, treating operands as two's complement.
- out_valid  output  1  registered; result captured last cycle.

Behaviour:
- All state updates on rising edge of clk only; no asynchronous paths to outputs.
- rst=1 at an edge:
  - Difference=0, Borrow=0, Zero=0, Overflow=0, out_valid=0.
  - rst has priority over in_valid.
- Slice equations for bit i with borrow-in b_i (b_0 = 0, or bin when the optional feature is enabled):
  - d_i = A_i ^ B_i ^ b_i
  - b_{i+1} = (~A_i & B_i) | (~(A_i ^ B_i) & b_i)
- Half-subtractor case (WIDTH=1, no bin): d = A ^ B; borrow = ~A & B.
- Borrow = b_WIDTH. Equals 1 exactly when A < B + bin (unsigned compare).
- Overflow = b_WIDTH ^ b_{WIDTH-1}. For WIDTH=1, Overflow = Borrow ^ b_0.
- Zero = (d == 0), computed from the combinational difference and registered together with it.
- Edge with rst=0 and in_valid=1:
  - Capture Difference, Borrow, Zero, Overflow.
  - out_valid <= 1.
- Edge with rst=0 and in_valid=0:
  - Difference, Borrow, Zero and Overflow hold their previous values.
  - out_valid <= 0.
- Latency: exactly 1 cycle from in_valid sample to out_valid.
- Throughput: one operation per cycle; back-to-back in_valid is allowed, with no stall or backpressure.
- Wrap-around: A=0, B=2^WIDTH-1 gives Difference=1, Borrow=1. A=B gives Difference=0, Zero=1, Borrow=0.
- Reset asserted mid-stream: the result of an operation sampled in the same cycle is discarded; out_valid=0 the next cycle.
- X on A/B while in_valid=0 must not corrupt held outputs.

Optional Feature:
- Macro SUBTRACTOR_BORROW_IN_EN.
- Defined:
  - Adds input port bin (1 bit), listed after B.
  - Slice 0 becomes a full subtractor with b_0 = bin.
  - bin is sampled with in_valid like A/B.
- Undefined:
  - No bin port; b_0 is tied to 0.
  - Slice 0 is a half subtractor.
  - Results equal the defined case with bin=0.

Test Plan:
- WIDTH=1, in_valid=1, apply (A,B) = 00, 01, 10, 11 on consecutive cycles. One cycle later each (Borrow, Difference) = 00, 11, 01, 00, with out_valid=1 each cycle.
- WIDTH=8, A=8'h00, B=8'hFF -> Difference=8'h01, Borrow=1, Zero=0. Then A=8'h5A, B=8'h5A -> Difference=8'h00, Borrow=0, Zero=1.
- WIDTH=8, A=8'h80, B=8'h01 -> Difference=8'h7F, Borrow=0, Overflow=1. Then A=8'h7F, B=8'hFF -> Difference=8'h80, Borrow=1, Overflow=1.
- Hold: capture A=8'h10, B=8'h03 (Difference=8'h0D). Then drop in_valid and change A/B for 3 cycles -> Difference stays 8'h0D, out_valid=0.
- Reset: assert rst together with in_valid=1, A=8'h05, B=8'h09 -> next cycle all outputs 0, out_valid=0. Deassert rst -> normal operation resumes on the next in_valid.
- SUBTRACTOR_BORROW_IN_EN defined, WIDTH=8, A=8'h00, B=8'h00, bin=1 -> Difference=8'hFF, Borrow=1. With bin=0 -> Difference=8'h00, Zero=1.
